// File: rtl/cv32e40s_ctrl_xfer_sched.sv
// Schedules the shared control-transfer target adder between an EX branch and an ID jump,
// and hands the resulting target to IF over a buffered valid/ready redirect.
module cv32e40s_ctrl_xfer_sched #(
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kill_i,
  input  logic                   bch_req_i,
  input  logic                   jmp_req_i,
  input  logic                   jmp_is_jalr_i,
  input  logic                   jalr_hazard_i,
  input  logic [31:0]            pc_target_i,
  output logic [1:0]             bch_jmp_mux_sel_o,
  output logic                   redir_valid_o,
  input  logic                   redir_ready_i,
  output logic [31:0]            redir_target_o,
  output logic                   redir_is_bch_o,
  output logic                   bch_stall_o,
  output logic                   jmp_stall_o,
  output logic [STALL_CNT_W-1:0] jalr_stall_cnt_o
);

  // bch_jmp_mux_e encoding
  localparam logic [1:0] CT_JAL  = 2'b01;
  localparam logic [1:0] CT_JALR = 2'b10;
  localparam logic [1:0] CT_BCH  = 2'b11;

  typedef enum logic [1:0] {StIdle, StJalrWait, StHold} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            hold_target_q;
  logic                   hold_is_bch_q;
  logic [1:0]             hold_sel_q;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic                   grant;
  logic                   hazard_stall;
  logic                   valid;
  logic                   is_bch;
  logic                   bch_stall;
  logic                   jmp_stall;
  logic [1:0]             sel;
  logic [31:0]            target;

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    hazard_stall = 1'b0;
    valid        = 1'b0;
    is_bch       = 1'b0;
    bch_stall    = 1'b0;
    jmp_stall    = 1'b0;
    sel          = CT_JALR;
    target       = pc_target_i;

    if (kill_i) begin
      state_d = StIdle;
    end else if (state_q == StHold) begin
      valid     = 1'b1;
      target    = hold_target_q;
      is_bch    = hold_is_bch_q;
      sel       = hold_sel_q;
      bch_stall = bch_req_i;
      jmp_stall = jmp_req_i;
      if (redir_ready_i) begin
        state_d = StIdle;
      end
    end else begin
      // Branch is older than the ID jump, so it always wins the adder.
      if (bch_req_i) begin
        grant     = 1'b1;
        sel       = CT_BCH;
        is_bch    = 1'b1;
        jmp_stall = jmp_req_i;
      end else if (jmp_req_i && (!jmp_is_jalr_i || !jalr_hazard_i)) begin
        grant = 1'b1;
        sel   = jmp_is_jalr_i ? CT_JALR : CT_JAL;
      end else if (jmp_req_i) begin
        hazard_stall = 1'b1;
        jmp_stall    = 1'b1;
        state_d      = StJalrWait;
      end else begin
        state_d = StIdle;
      end

      if (grant) begin
        valid   = 1'b1;
        state_d = redir_ready_i ? StIdle : StHold;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_target_q <= '0;
      hold_is_bch_q <= 1'b0;
      hold_sel_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      if (kill_i) begin
        hold_target_q <= '0;
        hold_is_bch_q <= 1'b0;
        hold_sel_q    <= '0;
      end else if (grant && !redir_ready_i) begin
        hold_target_q <= pc_target_i;
        hold_is_bch_q <= is_bch;
        hold_sel_q    <= sel;
      end
      if (hazard_stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Handshake and stall outputs are quiet while reset is held.
  assign redir_valid_o     = valid & rst_n;
  assign bch_stall_o       = bch_stall & rst_n;
  assign jmp_stall_o       = jmp_stall & rst_n;
  assign redir_target_o    = target;
  assign redir_is_bch_o    = is_bch;
  assign bch_jmp_mux_sel_o = sel;
  assign jalr_stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cv32e40s_ctrl_xfer_sched.sv
// Directed bench: stimulus queues expected redirects, a negedge monitor checks them.
module tb_cv32e40s_ctrl_xfer_sched;

  localparam logic [1:0] CT_JAL  = 2'b01;
  localparam logic [1:0] CT_JALR = 2'b10;
  localparam logic [1:0] CT_BCH  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill_i = 1'b0, bch_req_i = 1'b0, jmp_req_i = 1'b0;
  logic        jmp_is_jalr_i = 1'b0, jalr_hazard_i = 1'b0, redir_ready_i = 1'b0;
  logic [31:0] pc_target_i = '0;
  logic [1:0]  sel, sel2;
  logic        valid, valid2, is_bch, is_bch2, bstall, bstall2, jstall, jstall2;
  logic [31:0] target, target2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;

  typedef struct {
    logic [31:0] t;
    logic        b;
    logic [1:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cv32e40s_ctrl_xfer_sched #(.STALL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .kill_i(kill_i), .bch_req_i(bch_req_i), .jmp_req_i(jmp_req_i),
    .jmp_is_jalr_i(jmp_is_jalr_i), .jalr_hazard_i(jalr_hazard_i), .pc_target_i(pc_target_i),
    .bch_jmp_mux_sel_o(sel), .redir_valid_o(valid), .redir_ready_i(redir_ready_i),
    .redir_target_o(target), .redir_is_bch_o(is_bch), .bch_stall_o(bstall),
    .jmp_stall_o(jstall), .jalr_stall_cnt_o(cnt)
  );

  cv32e40s_ctrl_xfer_sched #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .kill_i(kill_i), .bch_req_i(bch_req_i), .jmp_req_i(jmp_req_i),
    .jmp_is_jalr_i(jmp_is_jalr_i), .jalr_hazard_i(jalr_hazard_i), .pc_target_i(pc_target_i),
    .bch_jmp_mux_sel_o(sel2), .redir_valid_o(valid2), .redir_ready_i(redir_ready_i),
    .redir_target_o(target2), .redir_is_bch_o(is_bch2), .bch_stall_o(bstall2),
    .jmp_stall_o(jstall2), .jalr_stall_cnt_o(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the redirect is valid it must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redir_unexpected: got target %h is_bch %b sel %b, none expected",
                 target, is_bch, sel);
      end else begin
        if (target !== exp_q[0].t || is_bch !== exp_q[0].b || sel !== exp_q[0].s) begin
          errors++;
          $display("FAIL redir: got %h/%b/%b expected %h/%b/%b", target, is_bch, sel,
                   exp_q[0].t, exp_q[0].b, exp_q[0].s);
        end
        if (redir_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge.
  task automatic cyc(input logic kill, input logic bch, input logic jmp, input logic jalr,
                     input logic haz, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    kill_i = kill; bch_req_i = bch; jmp_req_i = jmp; jmp_is_jalr_i = jalr;
    jalr_hazard_i = haz; pc_target_i = tgt; redir_ready_i = rdy;
  endtask

  task automatic expect_redir(input logic [31:0] t, input logic b, input logic [1:0] s);
    exp_t e;
    e.t = t; e.b = b; e.s = s;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_stalls", {30'b0, bstall, jstall}, 32'd0);
    chk("rst_cnt", {24'b0, cnt}, 32'd0);
    #3 rst_n = 1'b1;

    // JAL alone
    cyc(0, 0, 1, 0, 0, 32'h0000_0480, 1);
    expect_redir(32'h480, 1'b0, CT_JAL);
    @(negedge clk);
    chk("jal_sel", {30'b0, sel}, {30'b0, CT_JAL});
    chk("jal_jstall", {31'b0, jstall}, 32'd0);
    cyc(0, 0, 0, 0, 0, 32'h0, 1);
    @(negedge clk);
    chk("idle_sel", {30'b0, sel}, {30'b0, CT_JALR});
    chk("idle_valid", {31'b0, valid}, 32'd0);

    // Branch and JAL together: branch first, JAL next cycle
    cyc(0, 1, 1, 0, 0, 32'h100, 1);
    expect_redir(32'h100, 1'b1, CT_BCH);
    @(negedge clk);
    chk("bj_jstall", {31'b0, jstall}, 32'd1);
    chk("bj_bstall", {31'b0, bstall}, 32'd0);
    cyc(0, 0, 1, 0, 0, 32'h104, 1);
    expect_redir(32'h104, 1'b0, CT_JAL);
    @(negedge clk);
    chk("bj2_jstall", {31'b0, jstall}, 32'd0);

    // Back-pressure: target held while IF is not ready
    cyc(0, 1, 0, 0, 0, 32'h2000, 0);
    expect_redir(32'h2000, 1'b1, CT_BCH);
    @(negedge clk);
    chk("bp_bstall", {31'b0, bstall}, 32'd0);
    cyc(0, 0, 1, 0, 0, 32'hDEAD, 0);
    @(negedge clk);
    chk("hold_jstall", {31'b0, jstall}, 32'd1);
    chk("hold_sel", {30'b0, sel}, {30'b0, CT_BCH});
    cyc(0, 0, 0, 0, 0, 32'hDEAD, 0);
    @(negedge clk);
    chk("hold_valid", {31'b0, valid}, 32'd1);
    cyc(0, 0, 0, 0, 0, 32'hDEAD, 1);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 32'hDEAD, 1);
    @(negedge clk);
    chk("bp_idle_valid", {31'b0, valid}, 32'd0);

    // JALR hazard for 4 cycles, then granted
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 32'h8000_0010, 1);
      @(negedge clk);
      chk("haz_jstall", {31'b0, jstall}, 32'd1);
      chk("haz_valid", {31'b0, valid}, 32'd0);
      chk("haz_sel", {30'b0, sel}, {30'b0, CT_JALR});
    end
    cyc(0, 0, 1, 1, 0, 32'h8000_0010, 1);
    expect_redir(32'h8000_0010, 1'b0, CT_JALR);
    @(negedge clk);
    chk("haz_cnt", {24'b0, cnt}, 32'd4);
    chk("haz_cnt_sat", {30'b0, cnt2}, 32'd3);
    chk("haz_grant_jstall", {31'b0, jstall}, 32'd0);

    // Two more hazard cycles, then a branch overtakes the waiting JALR
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 1, 1, 32'h500, 1);
      @(negedge clk);
    end
    cyc(0, 1, 1, 1, 1, 32'h300, 1);
    expect_redir(32'h300, 1'b1, CT_BCH);
    @(negedge clk);
    chk("wait_bch_jstall", {31'b0, jstall}, 32'd1);
    cyc(0, 0, 0, 0, 0, 32'h0, 1);
    @(negedge clk);
    chk("cnt6", {24'b0, cnt}, 32'd6);
    chk("cnt_sat_hold", {30'b0, cnt2}, 32'd3);

    // Kill while holding 0x40
    cyc(0, 0, 1, 0, 0, 32'h40, 0);
    expect_redir(32'h40, 1'b0, CT_JAL);
    @(negedge clk);
    cyc(1, 1, 1, 0, 0, 32'h40, 1);
    exp_q.delete();
    @(negedge clk);
    chk("kill_valid", {31'b0, valid}, 32'd0);
    chk("kill_stalls", {30'b0, bstall, jstall}, 32'd0);
    cyc(0, 0, 0, 0, 0, 32'h40, 1);
    @(negedge clk);
    chk("kill_idle_valid", {31'b0, valid}, 32'd0);
    chk("kill_cnt", {24'b0, cnt}, 32'd6);

    // Reset asserted mid-HOLD
    cyc(0, 1, 0, 0, 0, 32'h77, 0);
    expect_redir(32'h77, 1'b1, CT_BCH);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_hold_valid", {31'b0, valid}, 32'd0);
    chk("rst_hold_cnt", {24'b0, cnt}, 32'd0);
    chk("rst_hold_cnt_sat", {30'b0, cnt2}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 32'h0, 1);
      @(negedge clk);
      chk("post_rst_valid", {31'b0, valid}, 32'd0);
    end

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
